// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with selectable standard/FWFT read, live fill level,
// programmable almost-full/almost-empty flags and sticky error flags.
module sync_fifo_ext #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          wr,
   input  logic                          rd,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          clr_err,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;

   // Status is a pure function of the pointer difference, so it never lags.
   assign level        = wr_ptr - rd_ptr;
   assign full         = (level == DEPTH_L);
   assign empty        = (level == '0);
   assign almost_full  = (level >= AF_L);
   assign almost_empty = (level <= AE_L);

   // A read frees a slot in the same cycle, so a write at full is accepted alongside it.
   assign rd_acc = rd && !empty;
   assign wr_acc = wr && (!full || rd_acc);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage is not reset; pointers alone define valid contents.
   always_ff @(posedge clk) begin
      if (reset_n && wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
   end

   // Sticky errors: a set in the same cycle as clr_err takes priority.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr && !wr_acc) || (overflow  && !clr_err);
         underflow <= (rd && !rd_acc) || (underflow && !clr_err);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = mem[rd_ptr[AW-1:0]];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] data_q;
         always_ff @(posedge clk) begin
            if (!reset_n)    data_q <= '0;
            else if (rd_acc) data_q <= mem[rd_ptr[AW-1:0]];
         end
         assign data_out = data_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// checks both against a queue-based reference model.
module tb_sync_fifo_ext;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFT   = DEPTH - 2;
   localparam int unsigned AET   = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr, rd, clr_err;
   logic [DW-1:0] data_in;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, af0, ae0, ov0, un0;
   logic          full1, empty1, af1, ae1, ov1, un1;
   logic [4:0]    level0, level1;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [DW-1:0] q[$];
   logic          m_ov, m_un;
   logic [DW-1:0] m_dout;

   always #5 clk = ~clk;

   sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0),
                   .AF_THRESH(AFT), .AE_THRESH(AET)) u_std (
      .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .data_in(data_in),
      .clr_err(clr_err), .data_out(dout0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .level(level0),
      .overflow(ov0), .underflow(un0));

   sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1),
                   .AF_THRESH(AFT), .AE_THRESH(AET)) u_fwft (
      .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .data_in(data_in),
      .clr_err(clr_err), .data_out(dout1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .level(level1),
      .overflow(ov1), .underflow(un1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("std_level",   32'(level0), 32'(n));
      chk("std_empty",   32'(empty0), 32'(n == 0));
      chk("std_full",    32'(full0),  32'(n == DEPTH));
      chk("std_af",      32'(af0),    32'(n >= AFT));
      chk("std_ae",      32'(ae0),    32'(n <= AET));
      chk("std_ovf",     32'(ov0),    32'(m_ov));
      chk("std_unf",     32'(un0),    32'(m_un));
      chk("std_dout",    32'(dout0),  32'(m_dout));
      chk("fwft_level",  32'(level1), 32'(n));
      chk("fwft_empty",  32'(empty1), 32'(n == 0));
      chk("fwft_full",   32'(full1),  32'(n == DEPTH));
      chk("fwft_af",     32'(af1),    32'(n >= AFT));
      chk("fwft_ae",     32'(ae1),    32'(n <= AET));
      chk("fwft_ovf",    32'(ov1),    32'(m_ov));
      chk("fwft_unf",    32'(un1),    32'(m_un));
      if (n != 0) chk("fwft_head", 32'(dout1), 32'(q[0]));
   endtask

   // One clock: drive inputs, advance the model by the FIFO's rules, check after the edge.
   task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      logic ra, wa;
      wr = w; rd = r; data_in = d; clr_err = c;
      ra = r && (q.size() > 0);
      wa = w && ((q.size() < DEPTH) || ra);
      @(posedge clk);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      m_ov = (w && !wa) || (m_ov && !c);
      m_un = (r && !ra) || (m_un && !c);
      #1;
      check_all();
   endtask

   task automatic do_reset(input logic w, input logic r);
      reset_n = 1'b0;
      wr = w; rd = r; data_in = 8'hEE; clr_err = 1'b0;
      @(posedge clk);
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_dout = '0;
      #1;
      check_all();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
      q.delete(); m_ov = 1'b0; m_un = 1'b0; m_dout = '0;
      @(posedge clk); #1;

      // reset with requests asserted: they must be ignored
      do_reset(1'b1, 1'b1);

      // fill 0x00..0x0F, then overflow attempt
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
      cycle(1'b1, 1'b0, 8'h99, 1'b0);
      chk("ovf_set", 32'(ov0), 32'd1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);

      // simultaneous write+read at full
      cycle(1'b1, 1'b1, 8'hAA, 1'b0);
      chk("full_wr_rd_level", 32'(level0), 32'd16);
      chk("full_wr_rd_ovf",   32'(ov0),    32'd0);
      chk("full_wr_rd_dout",  32'(dout0),  32'h00);

      // drain: 0x01..0x0F then 0xAA last
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_last", 32'(dout0), 32'hAA);

      // simultaneous write+read at empty
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      chk("empty_wr_rd_unf",   32'(un0),    32'd1);
      chk("empty_wr_rd_level", 32'(level0), 32'd1);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk("read_55", 32'(dout0), 32'h55);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk("clr_unf", 32'(un0), 32'd0);

      // FWFT fall-through without rd
      cycle(1'b1, 1'b0, 8'h3C, 1'b0);
      chk("fwft_head_3c", 32'(dout1),  32'h3C);
      chk("fwft_nonempty", 32'(empty1), 32'd0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk("fwft_pop_empty", 32'(empty1), 32'd1);

      // random bursts across many pointer wraps
      for (int b = 0; b < 40; b++) begin
         int len, mode;
         len  = int'($urandom_range(1, 12));
         mode = int'($urandom_range(0, 2));
         for (int k = 0; k < len; k++) begin
            logic w, r, c;
            case (mode)
               0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 2); end
               1:       begin w = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 8); end
               default: begin w = 1'($urandom); r = 1'($urandom); end
            endcase
            c = ($urandom_range(0, 15) == 0);
            cycle(w, r, 8'($urandom), c);
         end
      end

      // mid-operation reset at level 9
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h90, 1'b0);
      cycle(1'b1, 1'b1, 8'h91, 1'b0);
      chk("pre_reset_level", 32'(level0), 32'd9);
      do_reset(1'b1, 1'b0);
      chk("post_reset_level", 32'(level0), 32'd0);
      chk("post_reset_ae",    32'(ae0),    32'd1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
